// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Multicycle control unit for the Mary/Shelley accumulator-stack datapath.
//   Sequences FETCH -> DECODE -> EXEC [-> WB] and drives the datapath write
//   enables and mux selects. Memory states (FETCH, EXEC of SPUT/SPEK/SPOP)
//   stretch until MemReady. Illegal opcodes trap to FAULT and opcode 31 parks
//   in HALT; both states are left only through reset.
//
//   Optional feature macro: CU_WAIT_TIMEOUT_EN
//     defined   - a memory state that sees WAIT_MAX consecutive cycles of
//                 MemReady=0 moves to FAULT and sets Timeout.
//     undefined - waits are unbounded, no wait counter, Timeout is 0.
//
// Ports
//   CLK           in   rising-edge clock
//   Reset         in   asynchronous active-low reset
//   OPCODE        in   [OPCODE_W-1:0] opcode from IR (sampled in DECODE only)
//   flagbit       in   '@' variant flag from IR (sampled in DECODE only)
//   MemReady      in   memory access completes this cycle
//   MemRead       out  memory read strobe
//   MemWrite      out  memory write strobe
//   MemDst        out  [2:0] address select: 000 PC, 100 SP, 101 SP-1
//   IRWrite       out  IR load enable
//   PCWrite       out  PC load enable
//   MaryWrite     out  Mary register enable
//   ShelleyWrite  out  Shelley register enable
//   SPWrite       out  SP register enable
//   MarySrc       out  [1:0] Mary source select
//   ShelleySrc    out  [1:0] Shelley source select
//   SPSrc         out  [1:0] SP source select
//   SrcB          out  ALU B select: 1 immediate, 0 Shelley
//   ALUOP         out  [ALUOP_W-1:0] ALU function (zero-extended)
//   Halted        out  sticky: HALT opcode executed
//   Illegal       out  sticky: illegal opcode decoded
//   Timeout       out  sticky: memory wait timed out

module multicycle_control_fsm #(
  parameter int OPCODE_W = 5,
  parameter int ALUOP_W  = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] OPCODE,
  input  logic                flagbit,
  input  logic                MemReady,
  output logic                MemRead,
  output logic                MemWrite,
  output logic [2:0]          MemDst,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                MaryWrite,
  output logic                ShelleyWrite,
  output logic                SPWrite,
  output logic [1:0]          MarySrc,
  output logic [1:0]          ShelleySrc,
  output logic [1:0]          SPSrc,
  output logic                SrcB,
  output logic [ALUOP_W-1:0]  ALUOP,
  output logic                Halted,
  output logic                Illegal,
  output logic                Timeout
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_FAULT
  } stateT;

  typedef enum logic [2:0] {
    OP_APUT, OP_SPUT, OP_AADD, OP_ASUB, OP_SPEK, OP_SPOP, OP_HALT, OP_ILLEGAL
  } opKindT;

  if (ALUOP_W < 4 || WAIT_MAX < 1) begin : gBadParams
    $error("multicycle_control_fsm: ALUOP_W must be >= 4 and WAIT_MAX >= 1");
  end

  stateT               state, stateNext;
  logic [OPCODE_W-1:0] opReg;
  logic                flagReg;
  opKindT              liveKind, opKind;
  logic                haltedReg, illegalReg;
  logic                waitHit;

  // Full-width compare, so any nonzero upper opcode bit lands in OP_ILLEGAL.
  function automatic opKindT decodeOp(input logic [OPCODE_W-1:0] op);
    case (op)
      OPCODE_W'(0):  return OP_APUT;
      OPCODE_W'(1):  return OP_SPUT;
      OPCODE_W'(2):  return OP_AADD;
      OPCODE_W'(3):  return OP_ASUB;
      OPCODE_W'(4):  return OP_SPEK;
      OPCODE_W'(5):  return OP_SPOP;
      OPCODE_W'(31): return OP_HALT;
      default:       return OP_ILLEGAL;
    endcase
  endfunction

  // DECODE steers on the live opcode; EXEC/WB use the copy latched leaving DECODE.
  assign liveKind = decodeOp(OPCODE);
  assign opKind   = decodeOp(opReg);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= S_FETCH;
      opReg      <= '0;
      flagReg    <= 1'b0;
      haltedReg  <= 1'b0;
      illegalReg <= 1'b0;
    end else begin
      state <= stateNext;
      if (state == S_DECODE) begin
        opReg   <= OPCODE;
        flagReg <= flagbit;
        if (liveKind == OP_HALT)    haltedReg  <= 1'b1;
        if (liveKind == OP_ILLEGAL) illegalReg <= 1'b1;
      end
    end
  end

  assign Halted  = haltedReg;
  assign Illegal = illegalReg;

`ifdef CU_WAIT_TIMEOUT_EN
  localparam int WAIT_W = $clog2(WAIT_MAX + 1);

  logic [WAIT_W-1:0] waitCnt;
  logic              memState;
  logic              timeoutReg;

  assign memState = (state == S_FETCH) ||
                    (state == S_EXEC && (opKind == OP_SPUT || opKind == OP_SPEK ||
                                         opKind == OP_SPOP));

  // waitCnt holds the waits already seen, so this cycle is the WAIT_MAX-th one.
  // MemReady=1 on that cycle is not a wait and the state advances normally.
  assign waitHit = memState && !MemReady && (waitCnt == WAIT_W'(WAIT_MAX - 1));

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      waitCnt    <= '0;
      timeoutReg <= 1'b0;
    end else begin
      if (waitHit) timeoutReg <= 1'b1;
      // Any state change (or a non-memory state) restarts the count, so each
      // memory state is entered with a clean counter.
      if (stateNext != state || !memState)
        waitCnt <= '0;
      else if (!MemReady && waitCnt != WAIT_W'(WAIT_MAX))
        waitCnt <= waitCnt + WAIT_W'(1);
    end
  end

  assign Timeout = timeoutReg;
`else
  assign waitHit = 1'b0;
  assign Timeout = 1'b0;
`endif

  // NOTE: every output and stateNext gets a default before the case so no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    stateNext    = state;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemDst       = 3'b000;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    MaryWrite    = 1'b0;
    ShelleyWrite = 1'b0;
    SPWrite      = 1'b0;
    MarySrc      = 2'b00;
    ShelleySrc   = 2'b00;
    SPSrc        = 2'b00;
    SrcB         = 1'b0;
    ALUOP        = '0;

    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = MemReady;
        PCWrite = MemReady;
        if (waitHit)       stateNext = S_FAULT;
        else if (MemReady) stateNext = S_DECODE;
      end

      S_DECODE: begin
        case (liveKind)
          OP_HALT:    stateNext = S_HALT;
          OP_ILLEGAL: stateNext = S_FAULT;
          default:    stateNext = S_EXEC;
        endcase
      end

      S_EXEC: begin
        case (opKind)
          OP_APUT: begin
            if (flagReg) begin
              ShelleyWrite = 1'b1;
              ShelleySrc   = 2'b01;
            end else begin
              MaryWrite = 1'b1;
              MarySrc   = 2'b11;
            end
            stateNext = S_FETCH;
          end
          OP_SPUT: begin
            MemWrite = 1'b1;
            MemDst   = 3'b100;
            SPSrc    = 2'b01;
            SPWrite  = MemReady;
            if (waitHit)       stateNext = S_FAULT;
            else if (MemReady) stateNext = S_FETCH;
          end
          OP_AADD, OP_ASUB: begin
            SrcB      = ~flagReg;
            ALUOP     = (opKind == OP_AADD) ? ALUOP_W'(4'b0010) : ALUOP_W'(4'b0011);
            stateNext = S_WB;
          end
          OP_SPEK, OP_SPOP: begin
            MemRead = 1'b1;
            MemDst  = (opKind == OP_SPEK) ? 3'b101 : 3'b100;
            if (waitHit)       stateNext = S_FAULT;
            else if (MemReady) stateNext = S_WB;
          end
          default: stateNext = S_FAULT;
        endcase
      end

      S_WB: begin
        case (opKind)
          OP_AADD, OP_ASUB: begin
            MaryWrite = 1'b1;
            MarySrc   = 2'b01;
          end
          OP_SPEK: begin
            MaryWrite    = ~flagReg;
            ShelleyWrite = flagReg;
          end
          OP_SPOP: begin
            MaryWrite = 1'b1;
            SPWrite   = 1'b1;
            SPSrc     = 2'b10;
          end
          default: ;
        endcase
        stateNext = S_FETCH;
      end

      S_HALT:  stateNext = S_HALT;
      S_FAULT: stateNext = S_FAULT;
      default: stateNext = S_FAULT;
    endcase
  end

endmodule
